// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter for 16 requesters with registered index/one-hot grant,
// release on done or dropped request, and a forced release after MAX_HOLD cycles.
module rr_grant_encoder #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic [N-1:0]   grant_onehot,
  output logic           timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q;
  logic [IDW-1:0] last_id_q;
  logic [IDW-1:0] grant_id_q;
  logic [N-1:0]   grant_onehot_q;
  logic           grant_valid_q;
  logic           timeout_q;
  logic [7:0]     hold_cnt_q;

  logic [IDW-1:0] win_id_d;
  logic           win_found_d;
  logic           holder_req;
  logic           forced;
  logic           release_d;

  // Search starts one past the last winner; the IDW-bit add wraps mod 16.
  always_comb begin : winner_search
    logic [IDW-1:0] idx;
    win_id_d    = '0;
    win_found_d = 1'b0;
    idx         = '0;
    for (int k = 1; k <= N; k++) begin
      idx = last_id_q + IDW'(k);
      if (!win_found_d && req[idx]) begin
        win_found_d = 1'b1;
        win_id_d    = idx;
      end
    end
  end

  assign holder_req = req[grant_id_q];
  assign forced     = (hold_cnt_q == HOLD_LAST);
  assign release_d  = done | ~holder_req | forced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_id_q      <= ID_LAST;
      hold_cnt_q     <= '0;
      grant_valid_q  <= 1'b0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && win_found_d) begin
            state_q        <= GRANT;
            grant_valid_q  <= 1'b1;
            grant_id_q     <= win_id_d;
            grant_onehot_q <= ONE_HOT0 << win_id_d;
            last_id_q      <= win_id_d;
            hold_cnt_q     <= '0;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q        <= IDLE;
            grant_valid_q  <= 1'b0;
            grant_id_q     <= '0;
            grant_onehot_q <= '0;
            // A done or a dropped request on the same cycle masks the timeout.
            timeout_q      <= forced & ~done & holder_req;
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_onehot = grant_onehot_q;
  assign timeout      = timeout_q;

endmodule
